disp_rr_switch: RTL

Parametrised successor to the first-layer dispatch device of the Adaptive PCIe switch. Each input word is classified by its top bits into one of CHANNELS per-class FIFOs. The FIFOs are drained onto a single registered output port by a round-robin arbiter with valid/ready flow control. Per-channel pause (almost-full) and empty flags go to the upstream layer, and a sticky Error flags dropped words.

---
 rtl/disp_pkg.sv | 20 ++
 rtl/disp_fifo_chan.sv | 59 +++++
 rtl/disp_rr_switch.sv | 111 +++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared constants and width helpers for the disp_rr_switch dispatch block.
package disp_pkg;

    localparam int DEF_DATA_SIZE = 10;
    localparam int DEF_MAIN_SIZE = 8;
    localparam int DEF_CHANNELS  = 4;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_AF_THRESH = 6;

    // Width of the class field that selects a channel.
    function automatic int sel_width(input int data_size, input int main_size);
        return data_size - main_size;
    endfunction

    // Width of a FIFO read/write pointer.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/disp_fifo_chan.sv
// Single-clock per-class FIFO with occupancy count and full/empty/almost-full flags.
module disp_fifo_chan
    import disp_pkg::*;
#(
    parameter int WIDTH     = DEF_MAIN_SIZE,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEF_AF_THRESH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            head,
    output logic [ptr_width(DEPTH):0]   count,
    output logic                        full,
    output logic                        empty,
    output logic                        afull
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Write the storage array on an accepted push.
    // NOTE: the array is deliberately not reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign afull = (count >= CNT_W'(AF_THRESH));

endmodule

// File: rtl/disp_rr_switch.sv
// Class-decoding dispatch switch: per-class FIFOs drained round-robin onto one registered port.
module disp_rr_switch
    import disp_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int MAIN_SIZE = DEF_MAIN_SIZE,
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEF_AF_THRESH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [DATA_SIZE-1:0]           in,
    output logic                           in_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [MAIN_SIZE-1:0]           out,
    output logic [DATA_SIZE-MAIN_SIZE-1:0] out_ch,
    output logic [CHANNELS-1:0]            pause,
    output logic [CHANNELS-1:0]            empty,
    output logic                           Error
);

    localparam int SEL_W = sel_width(DATA_SIZE, MAIN_SIZE);
    localparam int CNT_W = ptr_width(DEPTH) + 1;

    logic [SEL_W-1:0]     sel;
    logic [SEL_W-1:0]     last;
    logic [SEL_W-1:0]     grant;
    logic                 grant_valid;
    logic                 load_en;
    logic [CHANNELS-1:0]  full;
    logic [CHANNELS-1:0]  busy;
    logic [CHANNELS-1:0]  push_en;
    logic [CHANNELS-1:0]  pop_en;
    logic [MAIN_SIZE-1:0] head  [CHANNELS];
    logic [CNT_W-1:0]     count [CHANNELS];

    assign sel      = in[DATA_SIZE-1:MAIN_SIZE];
    assign in_ready = ~full[sel];
    assign load_en  = ~out_valid | out_ready;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign push_en[i] = in_valid && in_ready && (sel == SEL_W'(i));
        assign pop_en[i]  = load_en && grant_valid && (grant == SEL_W'(i));
        assign busy[i]    = (count[i] != '0);

        disp_fifo_chan #(
            .WIDTH     (MAIN_SIZE),
            .DEPTH     (DEPTH),
            .AF_THRESH (AF_THRESH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push_en[i]),
            .pop   (pop_en[i]),
            .din   (in[MAIN_SIZE-1:0]),
            .head  (head[i]),
            .count (count[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .afull (pause[i])
        );
    end

    // Round-robin grant: first non-empty channel after the last one served.
    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    always_comb begin
        logic [SEL_W-1:0] idx;
        grant       = last;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = last + SEL_W'(k);
            if (!grant_valid && busy[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

    // Output register: reload from the granted FIFO whenever the held word is free to move.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            last      <= SEL_W'(CHANNELS - 1);
        end else if (load_en) begin
            if (grant_valid) begin
                out       <= head[grant];
                out_ch    <= grant;
                out_valid <= 1'b1;
                last      <= grant;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Sticky overflow flag: set when a presented word cannot be accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Error <= 1'b0;
        end else if (in_valid && !in_ready) begin
            Error <= 1'b1;
        end
    end

endmodule
